// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: takes a length-prefixed, XOR-checksummed program image,
// writes it word by word into imem and keeps the core in reset until it is verified.
module imem_boot_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_reset,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [ADDR_WIDTH:0] WL_ONE    = 1;
   localparam logic [16:0]         MAX_WORDS = 17'(1) << ADDR_WIDTH;

   state_t              state_q, state_d;
   logic [7:0]          len_hi_q;
   logic [ADDR_WIDTH:0] len_q;
   logic [ADDR_WIDTH:0] wl_q;
   logic [23:0]         asm_q;
   logic [1:0]          byte_idx_q;
   logic [7:0]          xor_q;
   logic                we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]         wdata_q;

   logic        take_hi, take_lo, take_data;
   logic        last_byte, last_word;
   logic [16:0] n_len;

   // Full word count as seen while the low length byte is on the bus.
   assign n_len     = {1'b0, len_hi_q, rx_data};
   assign last_byte = (byte_idx_q == 2'd3);
   assign last_word = ((wl_q + WL_ONE) == len_q);

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_LEN_HI;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      rx_ready  = 1'b0;
      take_hi   = 1'b0;
      take_lo   = 1'b0;
      take_data = 1'b0;
      unique case (state_q)
         S_LEN_HI: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               take_hi = 1'b1;
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               take_lo = 1'b1;
               if (n_len > MAX_WORDS)   state_d = S_ERR;
               else if (n_len == 17'd0) state_d = S_CSUM;
               else                     state_d = S_DATA;
            end
         end
         S_DATA: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               take_data = 1'b1;
               if (last_byte && last_word) state_d = S_CSUM;
            end
         end
         S_CSUM: begin
            rx_ready = 1'b1;
            if (rx_valid) state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
         end
         S_DONE, S_ERR: begin
         end
         default: state_d = S_LEN_HI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_hi_q   <= '0;
         len_q      <= '0;
         wl_q       <= '0;
         asm_q      <= '0;
         byte_idx_q <= '0;
         xor_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         we_q <= 1'b0;
         if (take_hi) len_hi_q <= rx_data;
         if (take_lo) len_q <= n_len[ADDR_WIDTH:0];
         if (take_data) begin
            xor_q      <= xor_q ^ rx_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            asm_q      <= {asm_q[15:0], rx_data};
            // Write happens alongside assembly of the next word; no stall needed.
            if (last_byte) begin
               we_q    <= 1'b1;
               addr_q  <= wl_q[ADDR_WIDTH-1:0];
               wdata_q <= {asm_q, rx_data};
               wl_q    <= wl_q + WL_ONE;
            end
         end
      end
   end

   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign words_loaded = wl_q;
   assign done         = (state_q == S_DONE);
   assign error        = (state_q == S_ERR);
   assign core_reset   = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: randomized byte streams checked every cycle against a
// model that derives all outputs from the list of bytes accepted since reset.
module tb_imem_boot_loader;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_ready, imem_we, core_reset, done, error;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   words_loaded;

   imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_reset(core_reset), .done(done),
      .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   logic [7:0]  mq[$];
   bit          last_acc = 0, rst_prev = 0, mon_en = 0;
   int          cyc = 0;
   int          log_addr[$];
   logic [31:0] log_data[$];
   int          log_cyc[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected outputs purely from the accepted-byte history.
   function automatic void model(output bit e_ready, output bit e_we, output bit e_done,
                                 output bit e_err, output int e_wl, output int e_addr,
                                 output logic [31:0] e_data);
      int n;
      int nw;
      logic [7:0] x;
      n = mq.size();
      e_ready = 1; e_we = 0; e_done = 0; e_err = 0; e_wl = 0; e_addr = 0; e_data = '0;
      if (n >= 2) begin
         nw = int'(mq[0]) * 256 + int'(mq[1]);
         if (nw > (1 << AW)) begin
            e_err = 1; e_ready = 0;
         end else begin
            e_wl = ((n - 2) / 4 < nw) ? (n - 2) / 4 : nw;
            if (n >= 3 + 4 * nw) begin
               x = 8'h00;
               for (int i = 2; i < 2 + 4 * nw; i++) x = x ^ mq[i];
               if (mq[2 + 4 * nw] == x) e_done = 1; else e_err = 1;
               e_ready = 0;
            end
            if (last_acc && n >= 6 && (n - 2) % 4 == 0 && (n - 2) / 4 <= nw) begin
               e_we   = 1;
               e_addr = (n - 2) / 4 - 1;
               e_data = {mq[n-4], mq[n-3], mq[n-2], mq[n-1]};
            end
         end
      end
   endfunction

   always @(negedge clk) begin
      bit er, ew, ed, ee;
      int ewl, ea;
      logic [31:0] edt;
      cyc++;
      if (imem_we === 1'b1) begin
         log_addr.push_back(int'(imem_addr));
         log_data.push_back(imem_wdata);
         log_cyc.push_back(cyc);
      end
      model(er, ew, ed, ee, ewl, ea, edt);
      if (mon_en) begin
         chk("rx_ready", rx_ready, er);
         chk("imem_we", imem_we, ew);
         chk("done", done, ed);
         chk("error", error, ee);
         chk("core_reset", core_reset, !ed);
         chk("words_loaded", words_loaded, ewl);
         if (ew) begin
            chk("imem_addr", imem_addr, ea);
            chk("imem_wdata", imem_wdata, edt);
         end
         if (rst_prev) begin
            chk("rst_addr", imem_addr, 0);
            chk("rst_wdata", imem_wdata, 0);
         end
      end
      if (reset) begin
         mq.delete();
         last_acc = 0; rst_prev = 1; mon_en = 1;
      end else begin
         rst_prev = 0;
         if (mon_en && rx_valid && er) begin
            mq.push_back(rx_data);
            last_acc = 1;
         end else last_acc = 0;
      end
   end

   task automatic do_reset();
      reset = 1'b1; rx_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic clear_log();
      log_addr.delete(); log_data.delete(); log_cyc.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b[$], input int gap_pct);
      foreach (b[i]) begin
         bit hs;
         hs = 0;
         for (int t = 0; t < 100 && !hs; t++) begin
            rx_valid = ($urandom_range(99) >= gap_pct);
            rx_data  = rx_valid ? b[i] : 8'($urandom);
            @(negedge clk);
            hs = rx_valid && rx_ready;
            @(posedge clk); #1;
         end
         if (!hs) begin
            vectors++; errors++;
            $display("FAIL send_timeout: byte %0d not accepted, required accept", i);
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic offer_extra(input int n);
      repeat (n) begin
         rx_valid = 1'b1; rx_data = 8'($urandom);
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
   endtask

   task automatic mk_stream(input logic [31:0] w[$], input logic [7:0] csum_flip,
                            output logic [7:0] s[$]);
      logic [7:0] x;
      s.delete();
      x = 8'h00;
      s.push_back(8'(w.size() >> 8));
      s.push_back(8'(w.size()));
      foreach (w[i]) begin
         for (int k = 3; k >= 0; k--) begin
            s.push_back(w[i][8*k +: 8]);
            x = x ^ w[i][8*k +: 8];
         end
      end
      s.push_back(x ^ csum_flip);
   endtask

   initial begin
      logic [7:0]  s1[$];
      logic [7:0]  s[$];
      logic [31:0] w[$];
      int          sa[$];
      logic [31:0] sd[$];

      s1 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
      idle(2);
      do_reset();

      // Two-word reference image, gap-free
      clear_log();
      send(s1, 0);
      idle(3);
      chk("t1_nwrites", log_addr.size(), 2);
      if (log_addr.size() >= 2) begin
         chk("t1_addr0", log_addr[0], 0);
         chk("t1_data0", log_data[0], 32'h20080005);
         chk("t1_addr1", log_addr[1], 1);
         chk("t1_data1", log_data[1], 32'h01095020);
         chk("t1_spacing", log_cyc[1] - log_cyc[0], 4);
      end
      chk("t1_done", done, 1);
      chk("t1_core_reset", core_reset, 0);
      chk("t1_rx_ready", rx_ready, 0);
      chk("t1_words", words_loaded, 2);

      // Bad checksum
      do_reset(); clear_log();
      s = s1; s[10] = 8'h00;
      send(s, 0);
      idle(2);
      offer_extra(4);
      chk("t2_error", error, 1);
      chk("t2_done", done, 0);
      chk("t2_core_reset", core_reset, 1);
      chk("t2_nwrites", log_addr.size(), 2);

      // Oversized length
      do_reset(); clear_log();
      s = '{8'h01, 8'h01};
      send(s, 0);
      idle(2);
      offer_extra(3);
      chk("t3_error", error, 1);
      chk("t3_nwrites", log_addr.size(), 0);

      // Empty image
      do_reset(); clear_log();
      s = '{8'h00, 8'h00, 8'h00};
      send(s, 0);
      idle(2);
      chk("t4_done", done, 1);
      chk("t4_core_reset", core_reset, 0);
      chk("t4_nwrites", log_addr.size(), 0);
      do_reset();
      s = '{8'h00, 8'h00, 8'h01};
      send(s, 0);
      idle(2);
      chk("t4b_error", error, 1);

      // Random 3-word image: gap-free vs. gappy valid must write the same
      w.delete();
      repeat (3) w.push_back($urandom);
      mk_stream(w, 8'h00, s);
      do_reset(); clear_log();
      send(s, 0);
      idle(2);
      sa = log_addr; sd = log_data;
      do_reset(); clear_log();
      send(s, 50);
      idle(2);
      chk("t5_nwrites", log_addr.size(), sa.size());
      chk("t5_nwrites_abs", sa.size(), 3);
      if (log_addr.size() == sa.size())
         foreach (sa[i]) begin
            chk("t5_addr", log_addr[i], sa[i]);
            chk("t5_data", log_data[i], sd[i]);
         end
      chk("t5_done", done, 1);

      // Reset after 6 payload bytes, then full image
      do_reset();
      s = s1[0:7];
      send(s, 0);
      do_reset(); clear_log();
      send(s1, 0);
      idle(2);
      chk("t6_nwrites", log_addr.size(), 2);
      if (log_addr.size() >= 1) begin
         chk("t6_addr0", log_addr[0], 0);
         chk("t6_data0", log_data[0], 32'h20080005);
      end
      chk("t6_done", done, 1);
      chk("t6_words", words_loaded, 2);

      // Random images, some corrupted, random gaps
      for (int r = 0; r < 6; r++) begin
         w.delete();
         repeat ($urandom_range(1, 6)) w.push_back($urandom);
         mk_stream(w, (r % 3 == 2) ? 8'($urandom_range(1, 255)) : 8'h00, s);
         do_reset();
         send(s, $urandom_range(0, 60));
         idle(3);
         offer_extra(2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $fatal(1, "watchdog");
   end

endmodule
